// File: rtl/sys_wdt_mc_if.sv
// Memory-mapped slave bus bundle for sys_wdt_mc: address, write data/strobe, combinational read data.
// Latency/backpressure: none at this level; the bus is a plain single-cycle register port.
interface sys_wdt_mc_if #(
    parameter int MM_ADDR_WIDTH = 8,
    parameter int MM_DATA_WIDTH = 16
);
    logic [MM_ADDR_WIDTH-1:0] addr;
    logic [MM_DATA_WIDTH-1:0] wdata;
    logic [MM_DATA_WIDTH-1:0] rdata;
    logic                     we;

    modport master (output addr, output wdata, output we, input rdata);
    modport slave  (input addr, input wdata, input we, output rdata);
endinterface

// File: rtl/sys_wdt_mc.sv
// Multi-channel password-kicked watchdog on the mm slave bus; window kicking when SWDT_WINDOW_EN is defined.
// Latency: writes act next cycle; timeout level 1 cycle after counter reaches 0, irq 1 cycle after the flag.
// Backpressure: none; one write accepted every cycle, reads are combinational from the address.
module sys_wdt_mc #(
    parameter int MM_ADDR_WIDTH = 8,
    parameter int MM_DATA_WIDTH = 16,
    parameter int NUM_CH        = 2,
    parameter int CNT_WIDTH     = 13,
    parameter int REG_ADDR_BASE = 'h20,
    parameter int RST_LOAD      = 'h0960
) (
    input  logic              clk_sys_i,
    input  logic              rst_i,
    sys_wdt_mc_if.slave       mm_s,
    input  logic              clk_8hz_i,
    output logic [NUM_CH-1:0] wdt_ot_o,
    output logic              wdt_irq_o
);

    localparam logic [7:0] CMD_KICK   = 8'h5A;
    localparam logic [7:0] CMD_EXPIRE = 8'hA5;
    localparam logic [CNT_WIDTH-1:0]     LOAD_INIT = CNT_WIDTH'(RST_LOAD);
    localparam logic [MM_ADDR_WIDTH-1:0] STAT_ADDR = MM_ADDR_WIDTH'(REG_ADDR_BASE + 8 * NUM_CH);

    function automatic logic [MM_ADDR_WIDTH-1:0] reg_addr(input int ch, input int ofs);
        return MM_ADDR_WIDTH'(REG_ADDR_BASE + 8 * ch + ofs);
    endfunction

    logic                 tick_smp;
    logic                 tick;
    logic [7:0]           cmd;
    logic [NUM_CH-1:0]    en_vec;
    logic [NUM_CH-1:0]    stat_set;
    logic [NUM_CH-1:0]    stat_clr;
    logic [NUM_CH-1:0]    stat_q;
    logic                 irq_q;
    logic [CNT_WIDTH-1:0] val_arr [NUM_CH];
`ifdef SWDT_WINDOW_EN
    logic [CNT_WIDTH-1:0] win_arr [NUM_CH];
`endif

    // Sample resets high so a tick source already high at release is not an edge.
    always_ff @(posedge clk_sys_i) begin
        if (rst_i) tick_smp <= 1'b1;
        else       tick_smp <= clk_8hz_i;
    end

    assign tick = ~tick_smp & clk_8hz_i;
    assign cmd  = mm_s.wdata[15:8];

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        logic                 ctrl_we;
        logic                 val_we;
        logic                 en_nxt;
        logic                 kick_ok;
        logic                 expired;
        logic                 en_q;
        logic                 ot_q;
        logic [CNT_WIDTH-1:0] val_q;
        logic [CNT_WIDTH-1:0] cnt_q;

        assign ctrl_we = mm_s.we && (mm_s.addr == reg_addr(n, 0));
        assign val_we  = mm_s.we && (mm_s.addr == reg_addr(n, 2));
        // Commands see the enable written in the same cycle.
        assign en_nxt  = ctrl_we ? mm_s.wdata[0] : en_q;
        assign expired = en_q && (cnt_q == '0);

`ifdef SWDT_WINDOW_EN
        logic                 win_we;
        logic [CNT_WIDTH-1:0] win_q;

        assign win_we  = mm_s.we && (mm_s.addr == reg_addr(n, 4));
        assign kick_ok = (cnt_q <= win_q);

        always_ff @(posedge clk_sys_i) begin
            if (rst_i)       win_q <= '1;
            else if (win_we) win_q <= mm_s.wdata[CNT_WIDTH-1:0];
        end

        assign win_arr[n] = win_q;
`else
        assign kick_ok = 1'b1;
`endif

        always_ff @(posedge clk_sys_i) begin
            if (rst_i) begin
                en_q  <= 1'b0;
                ot_q  <= 1'b0;
                val_q <= LOAD_INIT;
                cnt_q <= LOAD_INIT;
            end else begin
                en_q <= en_nxt;
                ot_q <= expired;
                if (val_we) val_q <= mm_s.wdata[CNT_WIDTH-1:0];
                if (!en_nxt) begin
                    cnt_q <= cnt_q;
                end else if (ctrl_we && cmd == CMD_KICK) begin
                    cnt_q <= kick_ok ? val_q : '0;
                end else if (ctrl_we && cmd == CMD_EXPIRE) begin
                    cnt_q <= '0;
                end else if (tick && cnt_q != '0) begin
                    cnt_q <= cnt_q - CNT_WIDTH'(1);
                end
            end
        end

        assign en_vec[n]   = en_q;
        assign val_arr[n]  = val_q;
        assign wdt_ot_o[n] = ot_q;
        // Flag sets on the same edge the timeout level rises.
        assign stat_set[n] = expired & ~ot_q;
    end

    assign stat_clr = (mm_s.we && mm_s.addr == STAT_ADDR) ? mm_s.wdata[NUM_CH-1:0] : '0;

    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            stat_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            stat_q <= (stat_q & ~stat_clr) | stat_set;
            irq_q  <= |stat_q;
        end
    end

    assign wdt_irq_o = irq_q;

    always_comb begin
        mm_s.rdata = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            if (mm_s.addr == reg_addr(n, 0)) mm_s.rdata[0] = en_vec[n];
            if (mm_s.addr == reg_addr(n, 2)) mm_s.rdata[CNT_WIDTH-1:0] = val_arr[n];
`ifdef SWDT_WINDOW_EN
            if (mm_s.addr == reg_addr(n, 4)) mm_s.rdata[CNT_WIDTH-1:0] = win_arr[n];
`endif
        end
        if (mm_s.addr == STAT_ADDR) mm_s.rdata[NUM_CH-1:0] = stat_q;
    end

endmodule

// File: tb/tb_sys_wdt_mc.sv
// Self-checking bench for sys_wdt_mc: directed scenarios with literal expectations, then random traffic
// compared every cycle against a behavioural model of the register map and counters.
module tb_sys_wdt_mc;
    localparam int AW = 8, DW = 16, NCH = 2, CW = 13, BASE = 'h20, LOAD = 'h0960;
    localparam int CMAX = (1 << CW) - 1;
    localparam int STAT_A = BASE + 8 * NCH;

    logic           clk, rst, clk8;
    logic [NCH-1:0] wdt_ot;
    logic           wdt_irq;
    int             checks = 0, failures = 0;
    bit             chk_on = 0;

    sys_wdt_mc_if #(.MM_ADDR_WIDTH(AW), .MM_DATA_WIDTH(DW)) mm ();

    sys_wdt_mc #(
        .MM_ADDR_WIDTH(AW), .MM_DATA_WIDTH(DW), .NUM_CH(NCH), .CNT_WIDTH(CW),
        .REG_ADDR_BASE(BASE), .RST_LOAD(LOAD)
    ) dut (
        .clk_sys_i(clk), .rst_i(rst), .mm_s(mm.slave), .clk_8hz_i(clk8),
        .wdt_ot_o(wdt_ot), .wdt_irq_o(wdt_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int m_cnt [NCH], m_val [NCH], m_win [NCH];
    bit m_en [NCH], m_ot [NCH], m_stat [NCH];
    bit m_irq, m_prev8;

    function automatic int model_rdata(input int a);
        int off, ch, sub;
        if (a < BASE) return 0;
        off = a - BASE; ch = off / 8; sub = off % 8;
        if (ch < NCH) begin
            if (sub == 0) return int'(m_en[ch]);
            if (sub == 2) return m_val[ch];
`ifdef SWDT_WINDOW_EN
            if (sub == 4) return m_win[ch];
`endif
            return 0;
        end
        if (ch == NCH && sub == 0) begin
            int s = 0;
            for (int i = 0; i < NCH; i++) if (m_stat[i]) s += (1 << i);
            return s;
        end
        return 0;
    endfunction

    always @(posedge clk) begin : model
        int off, wch, wsub, cmd, d;
        bit tk, any, en_new, expd;
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                m_cnt[i] = LOAD; m_val[i] = LOAD; m_win[i] = CMAX;
                m_en[i] = 0; m_ot[i] = 0; m_stat[i] = 0;
            end
            m_irq = 0; m_prev8 = 1;
        end else begin
            tk = (m_prev8 == 0) && (clk8 == 1);
            m_prev8 = clk8;
            any = 0;
            for (int i = 0; i < NCH; i++) any |= m_stat[i];
            m_irq = any;
            wch = -1; wsub = -1; d = int'(mm.wdata); cmd = (d >> 8) & 'hFF;
            if (mm.we && int'(mm.addr) >= BASE) begin
                off = int'(mm.addr) - BASE; wch = off / 8; wsub = off % 8;
            end
            for (int i = 0; i < NCH; i++) begin
                expd = m_en[i] && (m_cnt[i] == 0);
                if (wch == NCH && wsub == 0 && d[i]) m_stat[i] = 0;
                if (expd && !m_ot[i]) m_stat[i] = 1;
                m_ot[i] = expd;
                en_new = (wch == i && wsub == 0) ? d[0] : m_en[i];
                if (wch == i && wsub == 2) m_val[i] = d & CMAX;
`ifdef SWDT_WINDOW_EN
                if (wch == i && wsub == 4) m_win[i] = d & CMAX;
`endif
                if (en_new) begin
                    if (wch == i && wsub == 0 && cmd == 'h5A)
                        m_cnt[i] = (m_cnt[i] <= m_win[i]) ? m_val[i] : 0;
                    else if (wch == i && wsub == 0 && cmd == 'hA5)
                        m_cnt[i] = 0;
                    else if (tk && m_cnt[i] > 0)
                        m_cnt[i] = m_cnt[i] - 1;
                end
                m_en[i] = en_new;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            int ot_exp;
            ot_exp = 0;
            for (int i = 0; i < NCH; i++) if (m_ot[i]) ot_exp += (1 << i);
            check("cyc_ot", int'(wdt_ot), ot_exp);
            check("cyc_irq", int'(wdt_irq), int'(m_irq));
            check("cyc_rdata", int'(mm.rdata), model_rdata(int'(mm.addr)));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic wr(input int a, input int d);
        mm.addr = AW'(a); mm.wdata = DW'(d); mm.we = 1'b1;
        cyc();
        mm.we = 1'b0;
    endtask

    task automatic rd(input int a, output int d);
        mm.addr = AW'(a); #1;
        d = int'(mm.rdata);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            clk8 = 1'b1; cyc();
            clk8 = 1'b0; cyc();
        end
    endtask

    initial begin
        int r;
        rst = 1'b1; clk8 = 1'b1; mm.we = 1'b0; mm.addr = '0; mm.wdata = '0;
        @(posedge clk); #1; chk_on = 1;
        repeat (3) cyc();
        rst = 1'b0;
        repeat (4) cyc();
        check("rst_ot", int'(wdt_ot), 0);
        check("rst_irq", int'(wdt_irq), 0);
        rd(BASE, r);     check("rst_ctrl0", r, 'h0000);
        rd(BASE + 2, r); check("rst_val0", r, 'h0960);
        rd(STAT_A, r);   check("rst_stat", r, 0);

        // Channel 0 counts 5 ticks to timeout.
        clk8 = 1'b0; cyc();
        wr(BASE + 2, 5); wr(BASE, 'h5A01);
        ticks(4);
        check("ch0_not_yet", int'(wdt_ot[0]), 0);
        ticks(1);
        check("ch0_timeout", int'(wdt_ot[0]), 1);
        check("ch1_untouched", int'(wdt_ot[1]), 0);
        rd(STAT_A, r); check("ch0_stat", r, 1);
        check("irq_lag", int'(wdt_irq), 0);
        cyc();
        check("irq_set", int'(wdt_irq), 1);
        wr(STAT_A, 1); wr(BASE, 0);

        // Channel 1 force expire; clear in the set cycle loses.
        wr(BASE + 8, 'hA501); wr(STAT_A, 2);
        check("ch1_expire", int'(wdt_ot[1]), 1);
        rd(STAT_A, r); check("set_wins", r, 2);
        cyc();
        wr(STAT_A, 2);
        check("irq_still", int'(wdt_irq), 1);
        cyc();
        check("irq_drop", int'(wdt_irq), 0);
        wr(BASE + 8, 0);

        // Freeze and resume.
        wr(BASE + 2, 6); wr(BASE, 'h5A01); ticks(3);
        wr(BASE, 0); ticks(10);
        check("frozen_ot", int'(wdt_ot[0]), 0);
        wr(BASE, 1); ticks(2);
        check("resume_ot0", int'(wdt_ot[0]), 0);
        ticks(1);
        check("resume_to", int'(wdt_ot[0]), 1);
        wr(STAT_A, 3);

        // VAL write does not load the counter.
        wr(BASE + 2, 4); wr(BASE, 'h5A01); ticks(1);
        wr(BASE + 2, 'h1FFF); ticks(3);
        check("val_no_load", int'(wdt_ot[0]), 1);
        rd(BASE + 2, r); check("val_rb", r, 'h1FFF);
        wr(BASE, 'h5A01); cyc(); cyc();
        check("kick_1fff", int'(wdt_ot[0]), 0);
        wr(STAT_A + 2, 'hFFFF);
        rd(STAT_A + 2, r); check("unmapped", r, 0);

`ifdef SWDT_WINDOW_EN
        wr(BASE + 8 + 2, 10); wr(BASE + 8 + 4, 4); wr(BASE + 8, 'h5A01);
        ticks(3); wr(BASE + 8, 'h5A01); cyc();
        check("win_early", int'(wdt_ot[1]), 1);
        wr(BASE + 8, 'h5A01); ticks(6); wr(BASE + 8, 'h5A01); cyc(); cyc();
        check("win_ok", int'(wdt_ot[1]), 0);
`endif

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            int ch, sub, a, d;
            if ($urandom_range(0, 399) == 0) rst = 1'b1;
            else rst = 1'b0;
            if ($urandom_range(0, 2) == 0) clk8 = ~clk8;
            mm.we = ($urandom_range(0, 3) == 0);
            ch = $urandom_range(0, NCH); sub = 2 * $urandom_range(0, 3);
            a = BASE + 8 * ch + sub;
            if ($urandom_range(0, 15) == 0) a = $urandom_range(0, 255);
            if (ch < NCH && sub == 0) begin
                case ($urandom_range(0, 3))
                    0: d = 'h5A00;
                    1: d = 'hA500;
                    default: d = $urandom_range(0, 255) << 8;
                endcase
                d += ($urandom_range(0, 7) != 0) ? 1 : 0;
            end else if ($urandom_range(0, 7) == 0) d = $urandom_range(0, 'hFFFF);
            else d = $urandom_range(0, 12);
            mm.addr = AW'(a); mm.wdata = DW'(d);
            cyc();
        end
        rst = 1'b0; mm.we = 1'b0;
        cyc(); cyc();
        chk_on = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
